// File: rtl/fft_input_loader_if.sv
// Handshake/data bundle between sample source, loader and stage-1 butterfly.
// master: source/sink side (tb or neighbours); slave: the loader itself.
interface fft_input_loader_if #(
  parameter int IN_W   = 16,
  parameter int CALC_W = 17
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [IN_W-1:0]   in_re;
  logic signed [IN_W-1:0]   in_im;
  logic                     out_valid;
  logic                     out_ready;
  logic [8*CALC_W-1:0]      calc_in;
  logic [23:0]              rotation;
  logic [1:0]               out_group;
  logic                     out_last;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, calc_in,
    input  rotation, out_group, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, calc_in,
    output rotation, out_group, out_last
  );
endinterface

// File: rtl/fft_input_loader.sv
// Frame loader for the 16-point radix-4 FFT: stores 16 natural-order
// samples per bank, drains four digit-reversed 4-sample groups.
// Ports: clk, rst (async, high), flush (sync clear), bus (slave modport):
//   in_valid/in_ready/in_re/in_im  - serial sample input
//   out_valid/out_ready/calc_in    - packed group to stage-1 butterfly
//   rotation (always 0), out_group (0..3), out_last (group 3)
// Macro FFT_LOADER_PINGPONG_EN: two banks (overlapped fill/drain);
// undefined: single bank, pointers stay at 0.
module fft_input_loader #(
  parameter int IN_W   = 16,
  parameter int CALC_W = 17
) (
  input logic              clk,
  input logic              rst,
  input logic              flush,
  fft_input_loader_if.slave bus
);

  localparam int SW = 2 * CALC_W;
  localparam int XW = CALC_W - IN_W;

`ifdef FFT_LOADER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic [SW-1:0]   mem_q [2][16];
  logic [1:0]      full_q, full_d;
  logic [3:0]      wr_idx_q, wr_idx_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [1:0]      rd_grp_q, rd_grp_d;
  logic            vld_q, vld_d;
  logic [4*SW-1:0] calc_q, calc_d;

  logic            wr_en;
  logic            rd_acc;
  logic            load;
  logic            ld_bank;
  logic [1:0]      ld_grp;
  logic [SW-1:0]   wr_word;

  assign bus.in_ready  = !full_q[wr_bank_q];
  assign bus.out_valid = vld_q;
  assign bus.calc_in   = calc_q;
  assign bus.rotation  = 24'h0;
  assign bus.out_group = rd_grp_q;
  assign bus.out_last  = vld_q && (rd_grp_q == 2'd3);

  assign wr_en  = bus.in_valid && !full_q[wr_bank_q];
  assign rd_acc = vld_q && bus.out_ready;

  assign wr_word = {
    {XW{bus.in_re[IN_W-1]}}, bus.in_re,
    {XW{bus.in_im[IN_W-1]}}, bus.in_im
  };

  always_comb begin
    full_d    = full_q;
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    rd_grp_d  = rd_grp_q;
    vld_d     = vld_q;
    calc_d    = calc_q;
    load      = 1'b0;
    ld_bank   = rd_bank_q;
    ld_grp    = 2'd0;

    if (wr_en) begin
      wr_idx_d = wr_idx_q + 4'd1;
      if (wr_idx_q == 4'd15) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d = PP ? ~wr_bank_q : 1'b0;
      end
    end

    // Only registered flags decide the next load, so a bank
    // completing on this edge is presented one cycle later.
    if (rd_acc && rd_grp_q == 2'd3) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d = PP ? ~rd_bank_q : 1'b0;
      if (PP && full_q[~rd_bank_q]) begin
        load    = 1'b1;
        ld_bank = ~rd_bank_q;
      end else begin
        vld_d    = 1'b0;
        rd_grp_d = 2'd0;
      end
    end else if (rd_acc) begin
      load   = 1'b1;
      ld_grp = rd_grp_q + 2'd1;
    end else if (!vld_q && full_q[rd_bank_q]) begin
      load = 1'b1;
    end

    // Group g, slot k holds x[g+4k]: address is {k, g}.
    if (load) begin
      vld_d    = 1'b1;
      rd_grp_d = ld_grp;
      for (int k = 0; k < 4; k++) begin
        calc_d[k*SW +: SW] = mem_q[ld_bank][{k[1:0], ld_grp}];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem_q[wr_bank_q][wr_idx_q] <= wr_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= 2'b00;
      wr_idx_q  <= 4'd0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_grp_q  <= 2'd0;
      vld_q     <= 1'b0;
      calc_q    <= '0;
    end else if (flush) begin
      full_q    <= 2'b00;
      wr_idx_q  <= 4'd0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_grp_q  <= 2'd0;
      vld_q     <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_grp_q  <= rd_grp_d;
      vld_q     <= vld_d;
      calc_q    <= calc_d;
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: ramp, backpressure, stream,
// flush and async reset; expected groups built from sample numbering.
module tb_fft_input_loader;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  int errs   = 0;
  int checks = 0;
  int stall_log [64];
  int stall_tot;

  fft_input_loader_if #(.IN_W(16), .CALC_W(17)) bus ();

  fft_input_loader #(.IN_W(16), .CALC_W(17)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [135:0] got,
    input logic [135:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] sx(input logic [15:0] v);
    return {v[15], v};
  endfunction

  // Sample n of a frame starting at base is re=base+n, im=-(base+n).
  function automatic logic [135:0] exp_grp(input int base, input int g);
    logic [135:0] r;
    int v;
    logic [15:0] re;
    logic [15:0] im;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      v  = base + g + 4 * k;
      re = v[15:0];
      im = 16'(-v);
      r[k*34 +: 34] = {sx(re), sx(im)};
    end
    return r;
  endfunction

  task automatic send_samples(input int base, input int cnt);
    int w;
    for (int n = 0; n < cnt; n++) begin
      w = 0;
      while (!bus.in_ready && w < 100) begin
        bus.in_valid = 1'b0;
        step();
        w++;
      end
      if (w >= 100) chk("in_ready_timeout", w, 0);
      stall_log[n] = w;
      stall_tot += w;
      bus.in_valid = 1'b1;
      bus.in_re = 16'(base + n);
      bus.in_im = 16'(-(base + n));
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int base, input int ng);
    int gi;
    int cyc;
    gi  = 0;
    cyc = 0;
    bus.out_ready = 1'b1;
    while (gi < ng && cyc < 200) begin
      if (bus.out_valid) begin
        chk($sformatf("grp%0d", gi), bus.calc_in,
            exp_grp(base + 16 * (gi / 4), gi % 4));
        chk("out_group", bus.out_group, gi % 4);
        chk("out_last", bus.out_last, (gi % 4) == 3);
        chk("rotation", bus.rotation, 0);
        gi++;
      end
      step();
      cyc++;
    end
    chk("drain_cnt", gi, ng);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_re = '0;
    bus.in_im = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_calc_in", bus.calc_in, 0);
    chk("rst_rotation", bus.rotation, 0);
    chk("rst_out_group", bus.out_group, 0);
    chk("rst_out_last", bus.out_last, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Ramp: group 0 one cycle after the 16th sample.
    bus.out_ready = 1'b1;
    stall_tot = 0;
    send_samples(0, 16);
    chk("lat_not_yet", bus.out_valid, 0);
    step();
    chk("lat_valid", bus.out_valid, 1);
    chk("g0_im_m4", bus.calc_in[50:34], 17'h1FFFC);
    chk("g0_re_12", bus.calc_in[135:119], 17'd12);
    drain(0, 4);
    chk("ramp_idle", bus.out_valid, 0);

    // Continuous stream of three frames.
    stall_tot = 0;
    fork
      send_samples(1000, 48);
      drain(1000, 12);
    join
`ifdef FFT_LOADER_PINGPONG_EN
    chk("pp_no_stall", stall_tot, 0);
`else
    chk("sb_stall16", stall_log[16], 5);
    chk("sb_stall32", stall_log[32], 5);
`endif

    // Backpressure held on group 1.
    bus.out_ready = 1'b0;
    send_samples(100, 16);
    step();
    chk("bp_g0_valid", bus.out_valid, 1);
    chk("bp_g0", bus.calc_in, exp_grp(100, 0));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_group", bus.out_group, 1);
      chk("bp_hold_data", bus.calc_in, exp_grp(100, 1));
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_g2", bus.calc_in, exp_grp(100, 2));
    chk("bp_g2_grp", bus.out_group, 2);
    step();
    chk("bp_g3", bus.calc_in, exp_grp(100, 3));
    chk("bp_g3_last", bus.out_last, 1);
    step();
    chk("bp_done", bus.out_valid, 0);

    // Flush after nine samples of a partial frame.
    send_samples(200, 9);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_in_ready", bus.in_ready, 1);
    chk("fl_out_valid", bus.out_valid, 0);
    send_samples(300, 16);
    drain(300, 4);

    // Async reset while group 2 is presented.
    bus.out_ready = 1'b1;
    send_samples(400, 16);
    c = 0;
    while (!(bus.out_valid && bus.out_group == 2) && c < 20) begin
      step();
      c++;
    end
    chk("pre_rst_g2", bus.calc_in, exp_grp(400, 2));
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", bus.out_valid, 0);
    chk("ar_calc_in", bus.calc_in, 0);
    chk("ar_out_group", bus.out_group, 0);
    chk("ar_out_last", bus.out_last, 0);
    chk("ar_in_ready", bus.in_ready, 1);
    #1;
    rst = 1'b0;
    step();
    send_samples(500, 16);
    drain(500, 4);
    chk("end_idle", bus.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
